if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the decode stage.

---
 rtl/if_pkg.sv | 17 +
 rtl/ifid_reg.sv | 52 +++++
 rtl/if_stage.sv | 142 ++++++++++++++
 tb/tb_if_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-stage types and constants
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with write enable and bubble flush
module ifid_reg #(
  parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  // Flush wins over a simultaneous write so a redirect never lets a stale fetch through.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = 32'h0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (we) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'h0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, req/ack fetch FSM, skid buffer, IF/ID register
module if_stage
  import if_pkg::fetch_state_t;
  import if_pkg::FETCH;
  import if_pkg::HOLD;
  import if_pkg::DRAIN;
  import if_pkg::next_pc;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwrite,
  input  logic        ifidwrite,
  input  logic        pcsrc,
  input  logic        flush,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  skid_q, skid_d;
  logic         req_q, req_d;
  logic         ifid_we;
  logic [31:0]  ifid_inst;
  logic         stall;
  logic [31:0]  pc_inc;

  assign stall  = !(pcwrite && ifidwrite);
  assign pc_inc = next_pc(pc_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    skid_d    = skid_q;
    req_d     = req_q;
    ifid_we   = 1'b0;
    ifid_inst = imem_rdata;
    case (state_q)
      FETCH: begin
        // An ack is only honoured while our own request is up (e.g. not right after reset).
        if (!req_q) begin
          if (pcsrc) begin
            pc_d = pc_target;
          end else begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (pcsrc) begin
            pc_d   = pc_target;
            addr_d = pc_target;
          end else if (stall) begin
            skid_d  = imem_rdata;
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            ifid_we = 1'b1;
            pc_d    = pc_inc;
            addr_d  = pc_inc;
          end
        end else if (pcsrc) begin
          pc_d    = pc_target;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (pcsrc) begin
          pc_d    = pc_target;
          addr_d  = pc_target;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          ifid_we   = 1'b1;
          ifid_inst = skid_q;
          pc_d      = pc_inc;
          addr_d    = pc_inc;
          req_d     = 1'b1;
          state_d   = FETCH;
        end
      end
      DRAIN: begin
        // Old request stays up with its original address until memory answers; data is discarded.
        if (pcsrc) begin
          pc_d = pc_target;
        end
        if (imem_ack) begin
          addr_d  = pcsrc ? pc_target : pc_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      skid_q  <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .we        (ifid_we),
    .flush     (flush || pcsrc),
    .pc_in     (pc_q),
    .inst_in   (ifid_inst),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwrite;
  logic        ifidwrite;
  logic        pcsrc;
  logic        flush;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int mem_lat   = 0;
  int mem_cnt   = 0;
  logic stray_ack = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pcwrite    (pcwrite),
    .ifidwrite  (ifidwrite),
    .pcsrc      (pcsrc),
    .flush      (flush),
    .pc_target  (pc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hDEAD, a[15:0]};
  endfunction

  task automatic mem_drive();
    if (imem_req) begin
      imem_ack   = (mem_cnt >= mem_lat);
      imem_rdata = inst_of(imem_addr);
    end else begin
      imem_ack   = stray_ack;
      imem_rdata = 32'hBAD0_BAD0;
    end
  endtask

  task automatic tick();
    logic r, a;
    mem_drive();
    r = imem_req;
    a = imem_ack;
    @(posedge clk);
    if (r && a) mem_cnt = 0;
    else if (r) mem_cnt = mem_cnt + 1;
    else mem_cnt = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; pcwrite = 1'b1; ifidwrite = 1'b1; pcsrc = 1'b0; flush = 1'b0;
    pc_target = 32'h0; mem_lat = 0; stray_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pcwrite = 1'b1; ifidwrite = 1'b1; pcsrc = 1'b0; flush = 1'b0;
    pc_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else pass_cnt++;
    total_cnt++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h want 0", pc_out); else pass_cnt++;
    total_cnt++; if (inst_out !== NOP) $display("FAIL reset_inst: got %h want %h", inst_out, NOP); else pass_cnt++;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      tick();
      total_cnt++; if (pc_out !== exp_pc || valid_out !== 1'b1)
        $display("FAIL b2b_pc[%0d]: got pc=%h v=%b want pc=%h v=1", i, pc_out, valid_out, exp_pc); else pass_cnt++;
      total_cnt++; if (inst_out !== {16'hDEAD, exp_pc[15:0]})
        $display("FAIL b2b_inst[%0d]: got %h want %h", i, inst_out, {16'hDEAD, exp_pc[15:0]}); else pass_cnt++;
    end
    total_cnt++; if (imem_addr !== 32'h10) $display("FAIL b2b_next_addr: got %h want 00000010", imem_addr); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    pcwrite = 1'b0; ifidwrite = 1'b0;
    tick();
    total_cnt++; if (pc_out !== 32'h4 || imem_req !== 1'b0)
      $display("FAIL stall_c1: got pc=%h req=%b want pc=4 req=0", pc_out, imem_req); else pass_cnt++;
    tick();
    total_cnt++; if (pc_out !== 32'h4 || imem_req !== 1'b0 || valid_out !== 1'b1)
      $display("FAIL stall_c2: got pc=%h req=%b v=%b want pc=4 req=0 v=1", pc_out, imem_req, valid_out); else pass_cnt++;
    pcwrite = 1'b1; ifidwrite = 1'b1;
    tick();
    total_cnt++; if (pc_out !== 32'h8 || inst_out !== 32'hDEAD_0008 || valid_out !== 1'b1)
      $display("FAIL stall_release: got pc=%h inst=%h v=%b want pc=8 inst=dead0008 v=1", pc_out, inst_out, valid_out); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hC)
      $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=c", imem_req, imem_addr); else pass_cnt++;
    tick();
    total_cnt++; if (pc_out !== 32'hC || inst_out !== 32'hDEAD_000C)
      $display("FAIL stall_after: got pc=%h inst=%h want pc=c inst=dead000c", pc_out, inst_out); else pass_cnt++;
  endtask

  task automatic test_drain();
    do_reset();
    mem_lat = 3;
    pcsrc = 1'b1; flush = 1'b1; pc_target = 32'h40;
    tick();
    pcsrc = 1'b0; flush = 1'b0;
    total_cnt++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || inst_out !== NOP)
      $display("FAIL drain_bubble: got pc=%h inst=%h v=%b want bubble", pc_out, inst_out, valid_out); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL drain_old_addr: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (valid_out !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1)
      $display("FAIL drain_swallow: got v=%b req=%b addr=%h want v=0 req=1 addr=40", valid_out, imem_req, imem_addr); else pass_cnt++;
    mem_lat = 0;
    tick();
    total_cnt++; if (pc_out !== 32'h40 || inst_out !== 32'hDEAD_0040 || valid_out !== 1'b1)
      $display("FAIL drain_target: got pc=%h inst=%h v=%b want pc=40 inst=dead0040 v=1", pc_out, inst_out, valid_out); else pass_cnt++;
  endtask

  task automatic test_redirect_on_ack();
    do_reset();
    tick(); tick(); tick(); tick();
    pcsrc = 1'b1; pc_target = 32'h80;
    tick();
    pcsrc = 1'b0;
    total_cnt++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || inst_out !== NOP)
      $display("FAIL redir_ack_bubble: got pc=%h inst=%h v=%b want bubble", pc_out, inst_out, valid_out); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h80)
      $display("FAIL redir_ack_addr: got req=%b addr=%h want req=1 addr=80", imem_req, imem_addr); else pass_cnt++;
    tick();
    total_cnt++; if (pc_out !== 32'h80 || inst_out !== 32'hDEAD_0080 || valid_out !== 1'b1)
      $display("FAIL redir_ack_target: got pc=%h inst=%h v=%b want pc=80 inst=dead0080 v=1", pc_out, inst_out, valid_out); else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    pcsrc = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    pcsrc = 1'b0;
    tick();
    total_cnt++; if (pc_out !== 32'hFFFF_FFFC || valid_out !== 1'b1)
      $display("FAIL wrap_pc: got pc=%h v=%b want pc=fffffffc v=1", pc_out, valid_out); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 00000000", imem_addr); else pass_cnt++;
    mem_lat = 3;
    pcsrc = 1'b1; pc_target = 32'h100;
    tick();
    pcsrc = 1'b0;
    total_cnt++; if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL wrap_drain: got v=%b req=%b addr=%h want v=0 req=1 addr=0", valid_out, imem_req, imem_addr); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_out !== 32'h0 || inst_out !== NOP || valid_out !== 1'b0)
      $display("FAIL rst_mid_drain: got req=%b addr=%h pc=%h inst=%h v=%b want reset values",
               imem_req, imem_addr, pc_out, inst_out, valid_out); else pass_cnt++;
    rst = 1'b0; stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    total_cnt++; if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL stray_ack: got v=%b req=%b addr=%h want v=0 req=1 addr=0", valid_out, imem_req, imem_addr); else pass_cnt++;
    mem_lat = 0;
    tick();
    total_cnt++; if (pc_out !== 32'h0 || inst_out !== 32'hDEAD_0000 || valid_out !== 1'b1)
      $display("FAIL post_rst_fetch: got pc=%h inst=%h v=%b want pc=0 inst=dead0000 v=1", pc_out, inst_out, valid_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_drain();
    test_redirect_on_ack();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
